resync_tx_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer on the write side of a data_resync channel.

---
 rtl/resync_tx_arbiter_if.sv | 27 ++
 rtl/resync_tx_arbiter.sv | 107 ++++++++++
 tb/tb_resync_tx_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/resync_tx_arbiter_if.sv
// Requester/resync-side bundle of the tx arbiter: request handshake plus the held word
// presented to the data_resync write port.
interface resync_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4
) ();
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic                   en;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_tgl;
  logic                   busy;

  modport master (
    output en, req_valid, req_data,
    input  req_ready, out_data, out_id, out_tgl, busy
  );

  modport slave (
    input  en, req_valid, req_data,
    output req_ready, out_data, out_id, out_tgl, busy
  );
endinterface

// File: rtl/resync_tx_arbiter.sv
// Round-robin arbiter feeding one slow-sampled resync path; each accepted word is held
// stable for HOLD cycles and tagged with its source ID and a change-toggle.
module resync_tx_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 8
) (
  input logic                clk,
  input logic                resetn,
  resync_tx_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [ID_W-1:0]  last_q;
  logic [WIDTH-1:0] data_q;
  logic [ID_W-1:0]  id_q;
  logic             tgl_q;
  logic             busy_q;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] grant_data;
  logic [N_REQ-1:0] ready;
  logic             transfer;

  // Scan from the requester after the last winner, wrapping modulo N_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_q) + k) % N_REQ);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    ready = '0;
    if (resetn && (state_q == StIdle) && bus.en && grant_vld) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = |(ready & bus.req_valid);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      data_q  <= '0;
      id_q    <= '0;
      tgl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (transfer) begin
            data_q  <= grant_data;
            id_q    <= grant_idx;
            tgl_q   <= ~tgl_q;
            last_q  <= grant_idx;
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          // Counter only reloads on accept, so it stops at zero rather than wrapping.
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.out_tgl   = tgl_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_resync_tx_arbiter.sv
// Directed and random checks of resync_tx_arbiter against a cycle model and word scoreboard.
module tb_resync_tx_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned HOLD  = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  resync_tx_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  resync_tx_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    int               id;
    logic             t;
  } word_t;

  word_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Stimulus state
  logic [N_REQ-1:0] pend = '0;
  logic [WIDTH-1:0] pdat[N_REQ];
  logic             en_drv = 1'b1;
  logic             rst_drv = 1'b0;
  bit               refill = 1'b0;

  // Reference model
  bit               m_hold = 1'b0;
  int               m_cnt = 0;
  int               m_last = N_REQ - 1;
  int               m_id = 0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_tgl = 1'b0;

  int               cyc_n = 0;
  int               last_chg = -1;
  logic             prev_tgl = 1'b0;
  logic [N_REQ-1:0] last_rdy;
  int               busy_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int gnt;
    int j;
    logic [N_REQ-1:0] exp_rdy;
    word_t w;
    resetn        = rst_drv;
    bus.en        = en_drv;
    bus.req_valid = pend;
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = pdat[i];
    #1;
    gnt = -1;
    if (rst_drv && !m_hold && en_drv) begin
      for (int k = 1; k <= N_REQ; k++) begin
        j = (m_last + k) % N_REQ;
        if (gnt < 0 && pend[j]) gnt = j;
      end
    end
    exp_rdy = '0;
    if (gnt >= 0) exp_rdy[gnt] = 1'b1;
    last_rdy = bus.req_ready;
    busy_acc += int'(bus.busy);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("ready_onehot", $onehot0(bus.req_ready), 1);
    @(posedge clk);
    if (!rst_drv) begin
      m_hold = 1'b0; m_cnt = 0; m_last = N_REQ - 1; m_data = '0; m_id = 0; m_tgl = 1'b0;
    end else if (m_hold) begin
      if (m_cnt == 0) m_hold = 1'b0;
      else m_cnt--;
    end else if (gnt >= 0) begin
      m_data = pdat[gnt]; m_id = gnt; m_tgl = ~m_tgl; m_last = gnt;
      m_cnt = HOLD - 1; m_hold = 1'b1;
      sb.push_back('{d: m_data, id: m_id, t: m_tgl});
      if (refill) pdat[gnt] = WIDTH'($urandom);
      else pend[gnt] = 1'b0;
    end
    #1;
    chk("out_data", bus.out_data, m_data);
    chk("out_id", bus.out_id, m_id);
    chk("out_tgl", bus.out_tgl, m_tgl);
    chk("busy", bus.busy, m_hold);
    if (!rst_drv) begin
      prev_tgl = bus.out_tgl;
      last_chg = -1;
    end else if (bus.out_tgl !== prev_tgl) begin
      prev_tgl = bus.out_tgl;
      if (sb.size() == 0) begin
        chk("sb_spurious_word", 1, 0);
      end else begin
        w = sb.pop_front();
        chk("sb_data", bus.out_data, w.d);
        chk("sb_id", bus.out_id, w.id);
        chk("sb_tgl", bus.out_tgl, w.t);
      end
      if (last_chg >= 0) chk("word_stable", (cyc_n - last_chg) >= HOLD + 1, 1);
      last_chg = cyc_n;
    end
    cyc_n++;
  endtask

  task automatic wait_grant(input int max, output int at);
    at = -1;
    for (int n = 0; n < max; n++) begin
      cyc();
      if (last_rdy != '0) begin
        at = cyc_n - 1;
        break;
      end
    end
    if (at < 0) chk("grant_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_drv = 1'b0; pend = '0; refill = 1'b0; en_drv = 1'b1;
    cyc();
    rst_drv = 1'b1;
  endtask

  initial begin
    int g0, g1, gp, bound;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N_REQ-1:0] rdy_or;
    for (int i = 0; i < N_REQ; i++) pdat[i] = WIDTH'(i + 1);

    // 1: reset held with all requesters valid
    pend = '1; rst_drv = 1'b0;
    repeat (3) cyc();
    chk("t1_busy", bus.busy, 0);
    chk("t1_out_data", bus.out_data, 0);
    chk("t1_out_id", bus.out_id, 0);
    chk("t1_out_tgl", bus.out_tgl, 0);
    rst_drv = 1'b1;
    cyc();
    chk("t1_first_grant", last_rdy, 4'b0001);
    do_reset();

    // 2: single requester, then immediate re-request
    pend[2] = 1'b1; pdat[2] = 4'hA;
    wait_grant(10, g0);
    chk("t2_ready", last_rdy, 4'b0100);
    chk("t2_out_data", bus.out_data, 4'hA);
    chk("t2_out_id", bus.out_id, 2);
    chk("t2_out_tgl", bus.out_tgl, 1);
    pend[2] = 1'b1; pdat[2] = 4'h5;
    busy_acc = 0;
    wait_grant(30, g1);
    chk("t2_spacing", g1 - g0, HOLD + 1);
    chk("t2_busy_cycles", busy_acc, HOLD);
    do_reset();

    // 3: all requesters continuously valid
    pend = '1; refill = 1'b1;
    gp = -1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(30, g1);
      chk("t3_order", last_rdy, 1 << exp_order[n]);
      if (gp >= 0) chk("t3_spacing", g1 - gp, HOLD + 1);
      gp = g1;
    end
    do_reset();

    // 4: en dropped during hold with a pending requester
    pend[0] = 1'b1;
    wait_grant(10, g0);
    en_drv = 1'b0; pend[1] = 1'b1;
    rdy_or = '0;
    repeat (HOLD + 3) begin
      cyc();
      rdy_or |= last_rdy;
    end
    chk("t4_no_ready", rdy_or, 0);
    chk("t4_hold_done", bus.busy, 0);
    en_drv = 1'b1;
    cyc();
    chk("t4_ready1", last_rdy, 4'b0010);
    do_reset();

    // 5: reset in the middle of a hold
    pend[1] = 1'b1;
    wait_grant(10, g0);
    bound = 0;
    while (m_cnt != 3 && bound < 20) begin
      cyc();
      bound++;
    end
    chk("t5_reached_cnt3", m_cnt, 3);
    rst_drv = 1'b0; pend = '1;
    cyc();
    chk("t5_busy", bus.busy, 0);
    chk("t5_out_data", bus.out_data, 0);
    chk("t5_out_id", bus.out_id, 0);
    chk("t5_out_tgl", bus.out_tgl, 0);
    rst_drv = 1'b1;
    cyc();
    chk("t5_req0_wins", last_rdy, 4'b0001);
    do_reset();

    // 6: random traffic
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && ($urandom % 4) == 0) begin
          pend[i] = 1'b1;
          pdat[i] = WIDTH'($urandom);
        end
      end
      en_drv = ($urandom % 8) != 0;
      cyc();
    end
    en_drv = 1'b1;
    bound = 0;
    while ((pend != '0 || m_hold) && bound < 200) begin
      cyc();
      bound++;
    end
    chk("t6_drained", pend, 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
